// File: rtl/display_timing_pkg.sv
// Shared 640x480@60 timing defaults, the coordinate type and the window FSM states
// used by the active-window decoder.
package display_timing_pkg;

    localparam int VGA_CW          = 10;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;

    typedef logic [VGA_CW-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/display_delay_line.sv
// WIDTH x LATENCY register chain with synchronous active-low clear; keeps every bit
// of the decoded pixel word on exactly the same delay.
module display_delay_line #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [LATENCY];

    // NOTE: this chain is a handful of flops, not a RAM, so clearing every stage is
    // cheap and guarantees no stale pixel escapes after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[LATENCY-1];

endmodule

// File: rtl/display_window.sv
// Active-window decoder: turns raw sync counts into data-enable, pixel coordinates
// and line/frame strobes, starting and stopping only on frame boundaries.
module display_window
    import display_timing_pkg::*;
#(
    parameter int CW          = VGA_CW,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END,
    parameter int SCALE_SHIFT = 0,
    parameter int LATENCY     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr_err,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    output logic          de,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic [CW-1:0] fb_x,
    output logic [CW-1:0] fb_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_end,
    output logic          running,
    output logic          sync_err
);

    localparam logic [CW-1:0] H_START = CW'(H_ACT_START);
    localparam logic [CW-1:0] H_END   = CW'(H_ACT_END);
    localparam logic [CW-1:0] V_START = CW'(V_ACT_START);
    localparam logic [CW-1:0] V_END   = CW'(V_ACT_END);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW:0]   H_LIMIT = (CW+1)'(H_TOTAL);
    localparam logic [CW:0]   V_LIMIT = (CW+1)'(V_TOTAL);

    typedef struct packed {
        logic          de;
        logic          line_start;
        logic          frame_start;
        logic          frame_end;
        logic [CW-1:0] posx;
        logic [CW-1:0] posy;
        logic [CW-1:0] fb_x;
        logic [CW-1:0] fb_y;
    } pix_t;

    state_e        state;
    logic          h_in_range;
    logic          v_in_range;
    logic          h_act;
    logic          v_act;
    logic          fb_pt;
    logic          last_pt;
    logic          de_raw;
    logic [CW-1:0] posx_raw;
    logic [CW-1:0] posy_raw;
    pix_t          stage0;
    pix_t          piped;

    logic [CW-1:0] prev_h;
    logic [CW-1:0] prev_v;
    logic [CW-1:0] exp_h;
    logic [CW-1:0] exp_v;
    logic          checked;
    logic          err_now;

    // Stage 0 decode; an out-of-range count can never look active.
    always_comb begin
        h_in_range = {1'b0, hcount} < H_LIMIT;
        v_in_range = {1'b0, vcount} < V_LIMIT;
        h_act      = h_in_range && (hcount >= H_START) && (hcount <= H_END);
        v_act      = v_in_range && (vcount >= V_START) && (vcount <= V_END);
        fb_pt      = (hcount == H_START) && (vcount == V_START);
        last_pt    = (hcount == H_END) && (vcount == V_END);
        de_raw     = h_act && v_act &&
                     ((state == RUN) || (state == STOP) ||
                      ((state == ARMED) && enable && fb_pt));
        posx_raw   = hcount - H_START;
        posy_raw   = vcount - V_START;
    end

    // NOTE: every field gets a default before the conditional update so that no
    // latch is inferred when de_raw is low.
    always_comb begin
        stage0 = '0;
        if (de_raw) begin
            stage0.de          = 1'b1;
            stage0.line_start  = (hcount == H_START);
            stage0.frame_start = fb_pt;
            stage0.frame_end   = last_pt;
            stage0.posx        = posx_raw;
            stage0.posy        = posy_raw;
            stage0.fb_x        = posx_raw >> SCALE_SHIFT;
            stage0.fb_y        = posy_raw >> SCALE_SHIFT;
        end
    end

    // NOTE: state is sequential, so it is only ever written with non-blocking
    // assignments; reads in the same edge see the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (enable) state <= ARMED;
                ARMED: begin
                    if (!enable)    state <= IDLE;
                    else if (fb_pt) state <= RUN;
                end
                RUN:     if (!enable) state <= STOP;
                STOP: begin
                    if (last_pt)     state <= IDLE;
                    else if (enable) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running = (state == RUN);

    display_delay_line #(
        .WIDTH  ($bits(pix_t)),
        .LATENCY(LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (stage0),
        .q    (piped)
    );

    assign de          = piped.de;
    assign line_start  = piped.line_start;
    assign frame_start = piped.frame_start;
    assign frame_end   = piped.frame_end;
    assign posx        = piped.posx;
    assign posy        = piped.posy;
    assign fb_x        = piped.fb_x;
    assign fb_y        = piped.fb_y;

    // Vertical count only advances on the cycle the horizontal count wraps.
    always_comb begin
        exp_h = (prev_h == H_LAST) ? '0 : prev_h + 1'b1;
        exp_v = prev_v;
        if (prev_h == H_LAST) begin
            exp_v = (prev_v == V_LAST) ? '0 : prev_v + 1'b1;
        end
        err_now = !h_in_range || !v_in_range ||
                  (checked && ((hcount != exp_h) || (vcount != exp_v)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_h   <= '0;
            prev_v   <= '0;
            checked  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            prev_h  <= hcount;
            prev_v  <= vcount;
            checked <= 1'b1;
            if (err_now) begin
                sync_err <= 1'b1;
            end else if (clr_err) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_window.sv
// Directed bench for display_window: four latency variants plus a scaled variant,
// all driven by the same hand-placed count sequence.
module tb_display_window;
    import display_timing_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   enable;
    logic   clr_err;
    coord_t hcount;
    coord_t vcount;

    logic [3:0]       de_w, ls_w, fs_w, fe_w, run_w, err_w;
    logic [3:0][9:0]  posx_w, posy_w, fbx_w, fby_w;

    logic   sc_de, sc_ls, sc_fs, sc_fe, sc_run, sc_err;
    coord_t sc_posx, sc_posy, sc_fbx, sc_fby;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_lat
        display_window #(.LATENCY(k + 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable     (enable),
            .clr_err    (clr_err),
            .hcount     (hcount),
            .vcount     (vcount),
            .de         (de_w[k]),
            .posx       (posx_w[k]),
            .posy       (posy_w[k]),
            .fb_x       (fbx_w[k]),
            .fb_y       (fby_w[k]),
            .line_start (ls_w[k]),
            .frame_start(fs_w[k]),
            .frame_end  (fe_w[k]),
            .running    (run_w[k]),
            .sync_err   (err_w[k])
        );
    end

    display_window #(.SCALE_SHIFT(1)) u_scale (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr_err    (clr_err),
        .hcount     (hcount),
        .vcount     (vcount),
        .de         (sc_de),
        .posx       (sc_posx),
        .posy       (sc_posy),
        .fb_x       (sc_fbx),
        .fb_y       (sc_fby),
        .line_start (sc_ls),
        .frame_start(sc_fs),
        .frame_end  (sc_fe),
        .running    (sc_run),
        .sync_err   (sc_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one count pair at a falling edge; return after the next falling edge.
    task automatic tick(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        @(negedge clk);
    endtask

    initial begin
        int nde, nls, nfs, nfe, nsls;
        int hs[4];
        hs = '{143, 144, 783, 784};

        rst_n   = 1'b0;
        enable  = 1'b1;
        clr_err = 1'b0;
        hcount  = '0;
        vcount  = '0;
        @(negedge clk);
        tick(0, 0);
        tick(0, 0);
        check("rst_de",      32'(de_w[0]),  0);
        check("rst_posx",    32'(posx_w[0]), 0);
        check("rst_fs",      32'(fs_w[0]),  0);
        check("rst_running", 32'(run_w[0]), 0);
        check("rst_err",     32'(err_w[0]), 0);
        check("rst_de_l4",   32'(de_w[3]),  0);

        // Enabled from reset: first frame starts at (144,35).
        rst_n = 1'b1;
        tick(0, 0);
        check("armed_running", 32'(run_w[0]), 0);
        tick(142, 35);
        check("pre_fb_de_142", 32'(de_w[0]), 0);
        tick(143, 35);
        check("pre_fb_de_143", 32'(de_w[0]), 0);
        tick(144, 35);
        check("fb_de",      32'(de_w[0]),  1);
        check("fb_posx",    32'(posx_w[0]), 0);
        check("fb_posy",    32'(posy_w[0]), 0);
        check("fb_fs",      32'(fs_w[0]),  1);
        check("fb_ls",      32'(ls_w[0]),  1);
        check("fb_running", 32'(run_w[0]), 1);
        tick(145, 35);
        check("fb1_de",   32'(de_w[0]),  1);
        check("fb1_posx", 32'(posx_w[0]), 1);
        check("fb1_fs",   32'(fs_w[0]),  0);
        check("fb1_ls",   32'(ls_w[0]),  0);

        nde = 0;
        nls = 0;
        for (int h = 0; h < 800; h++) begin
            tick(h, 36);
            nde += 32'(de_w[0]);
            nls += 32'(ls_w[0]);
            if (h == 783) begin
                check("line_last_posx", 32'(posx_w[0]), 639);
                check("line_last_posy", 32'(posy_w[0]), 1);
            end
            if (h == 784) begin
                check("line_after_de",   32'(de_w[0]),  0);
                check("line_after_posx", 32'(posx_w[0]), 0);
            end
        end
        check("line_de_count", nde, 640);
        check("line_ls_count", nls, 1);

        // Sparse frame sweep: two active samples per active line.
        nde = 0; nls = 0; nfs = 0; nfe = 0; nsls = 0;
        for (int v = 0; v < 525; v++) begin
            for (int j = 0; j < 4; j++) begin
                tick(hs[j], v);
                nde  += 32'(de_w[0]);
                nls  += 32'(ls_w[0]);
                nfs  += 32'(fs_w[0]);
                nfe  += 32'(fe_w[0]);
                nsls += 32'(sc_ls);
            end
        end
        check("frame_de_count",   nde,  960);
        check("frame_ls_count",   nls,  480);
        check("frame_fs_count",   nfs,  1);
        check("frame_fe_count",   nfe,  1);
        check("scale_ls_count",   nsls, 480);

        tick(783, 514);
        check("last_de",   32'(de_w[0]),  1);
        check("last_posx", 32'(posx_w[0]), 639);
        check("last_posy", 32'(posy_w[0]), 479);
        check("last_fe",   32'(fe_w[0]),  1);
        check("last_sc_fbx", 32'(sc_fbx), 319);
        check("last_sc_fby", 32'(sc_fby), 239);

        // Pixel replication by two.
        tick(149, 42);
        check("sc_posx_5", 32'(sc_posx), 5);
        check("sc_fbx_5",  32'(sc_fbx),  2);
        check("sc_fby_7",  32'(sc_fby),  3);
        tick(150, 42);
        check("sc_fbx_6",  32'(sc_fbx),  3);
        tick(151, 42);
        check("sc_fbx_7",  32'(sc_fbx),  3);
        tick(152, 42);
        check("sc_fbx_8",  32'(sc_fbx),  4);
        check("noscale_fbx_8", 32'(fbx_w[0]), 8);

        // Latency sweep: output of variant k shows the input from k+1 edges ago.
        for (int i = 0; i < 4; i++) tick(100, 40);
        for (int t = 0; t < 7; t++) begin
            tick(142 + t, 40);
            for (int k = 0; k < 4; k++) begin
                int idx;
                logic exp_de;
                idx    = t - k;
                exp_de = (idx >= 2);
                check($sformatf("lat%0d_t%0d_de", k + 1, t),   32'(de_w[k]), 32'(exp_de));
                check($sformatf("lat%0d_t%0d_posx", k + 1, t), 32'(posx_w[k]),
                      exp_de ? 32'(idx - 2) : 0);
                check($sformatf("lat%0d_t%0d_posy", k + 1, t), 32'(posy_w[k]),
                      exp_de ? 5 : 0);
                check($sformatf("lat%0d_t%0d_ls", k + 1, t),   32'(ls_w[k]),
                      (idx == 2) ? 1 : 0);
            end
        end

        // Stop at end of frame, then restart mid-frame.
        enable = 1'b0;
        tick(300, 60);
        check("stop_de_still",  32'(de_w[0]),  1);
        check("stop_running",   32'(run_w[0]), 0);
        tick(783, 514);
        check("stop_last_de",   32'(de_w[0]),  1);
        check("stop_last_fe",   32'(fe_w[0]),  1);
        tick(0, 0);
        check("idle_running",   32'(run_w[0]), 0);
        enable = 1'b1;
        tick(300, 200);
        check("mid_en_de",      32'(de_w[0]), 0);
        tick(301, 200);
        check("armed_act_de",   32'(de_w[0]), 0);
        tick(144, 40);
        check("armed_ls_de",    32'(de_w[0]), 0);
        tick(783, 514);
        check("armed_fe",       32'(fe_w[0]), 0);
        tick(144, 35);
        check("restart_de",     32'(de_w[0]), 1);
        check("restart_fs",     32'(fs_w[0]), 1);
        enable = 1'b0;
        tick(400, 100);
        check("drop_de",        32'(de_w[0]),  1);
        check("drop_running",   32'(run_w[0]), 0);
        tick(500, 300);
        check("drop_mid_de",    32'(de_w[0]), 1);
        tick(783, 514);
        check("drop_last_fe",   32'(fe_w[0]), 1);
        tick(0, 0);
        tick(144, 35);
        check("next_frame_de",  32'(de_w[0]), 0);
        check("next_frame_fs",  32'(fs_w[0]), 0);
        tick(300, 100);
        check("next_frame_mid", 32'(de_w[0]), 0);

        // STOP returns to RUN when enable comes back before the last pixel.
        enable = 1'b1;
        tick(144, 35);
        tick(144, 35);
        check("rerun_de", 32'(de_w[0]), 1);
        enable = 1'b0;
        tick(200, 50);
        enable = 1'b1;
        tick(201, 50);
        check("stop_to_run_de",      32'(de_w[0]),  1);
        check("stop_to_run_running", 32'(run_w[0]), 1);

        // Synchronous reset mid-frame.
        tick(499, 300);
        check("pre_rst_de", 32'(de_w[0]), 1);
        rst_n = 1'b0;
        tick(500, 300);
        check("mrst_de",      32'(de_w[0]),  0);
        check("mrst_posx",    32'(posx_w[0]), 0);
        check("mrst_posy",    32'(posy_w[0]), 0);
        check("mrst_running", 32'(run_w[0]), 0);
        check("mrst_err",     32'(err_w[0]), 0);
        check("mrst_de_l4",   32'(de_w[3]),  0);
        rst_n = 1'b1;
        tick(501, 300);
        check("mrst_resume_de", 32'(de_w[0]),  0);
        check("mrst_skip_err",  32'(err_w[0]), 0);
        tick(144, 40);
        check("mrst_armed_de",  32'(de_w[0]),  0);
        tick(144, 35);
        check("mrst_fb_de",      32'(de_w[0]),  1);
        check("mrst_fb_fs",      32'(fs_w[0]),  1);
        check("mrst_fb_running", 32'(run_w[0]), 1);

        // Sync discontinuity checking.
        tick(198, 50);
        check("jump_err",        32'(err_w[0]), 1);
        clr_err = 1'b1;
        tick(199, 50);
        check("clr_err",         32'(err_w[0]), 0);
        clr_err = 1'b0;
        tick(200, 50);
        check("contig_err",      32'(err_w[0]), 0);
        tick(205, 50);
        check("jump205_err",     32'(err_w[0]), 1);
        tick(206, 50);
        check("sticky_err",      32'(err_w[0]), 1);
        clr_err = 1'b1;
        tick(207, 50);
        check("clr2_err",        32'(err_w[0]), 0);
        clr_err = 1'b0;
        tick(208, 50);
        check("contig2_err",     32'(err_w[0]), 0);
        clr_err = 1'b1;
        tick(213, 50);
        check("set_wins_err",    32'(err_w[0]), 1);
        clr_err = 1'b0;
        tick(214, 50);
        check("set_wins_hold",   32'(err_w[0]), 1);
        clr_err = 1'b1;
        tick(799, 50);
        check("pre_wrap_err",    32'(err_w[0]), 1);
        tick(0, 51);
        check("hwrap_err",       32'(err_w[0]), 0);
        clr_err = 1'b0;
        tick(1, 51);
        check("hwrap_next_err",  32'(err_w[0]), 0);
        clr_err = 1'b1;
        tick(799, 524);
        check("pre_vwrap_err",   32'(err_w[0]), 1);
        tick(0, 0);
        check("vwrap_err",       32'(err_w[0]), 0);
        clr_err = 1'b0;
        tick(900, 0);
        check("range_err",       32'(err_w[0]), 1);
        check("range_de",        32'(de_w[0]),  0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
